// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready command in, APB SETUP/ACCESS out, valid/ready response back.
// Optional ACCESS-phase timeout is built only when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("apb_master_bridge: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t              state, state_n;
    logic                cmd_ready_n;
    logic                rsp_valid_n;
    logic [DATA_W-1:0]   rsp_rdata_n;
    logic [ADDR_W-1:0]   paddr_n;
    logic                psel_n;
    logic                penable_n;
    logic                pwrite_n;
    logic [DATA_W-1:0]   pwdata_n;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [15:0] wait_cnt, wait_cnt_n;
    logic        rsp_err_q, rsp_err_n;

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Every output is computed one cycle ahead here and registered below,
    // so nothing reaches a port without passing through a flop.
    always_comb begin
        state_n     = state;
        cmd_ready_n = cmd_ready;
        rsp_valid_n = rsp_valid;
        rsp_rdata_n = rsp_rdata;
        paddr_n     = paddr;
        psel_n      = psel;
        penable_n   = penable;
        pwrite_n    = pwrite;
        pwdata_n    = pwdata;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_n  = wait_cnt;
        rsp_err_n   = rsp_err_q;
`endif

        case (state)
            IDLE: begin
                cmd_ready_n = 1'b1;
                psel_n      = 1'b0;
                penable_n   = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    paddr_n     = cmd_addr;
                    pwrite_n    = cmd_write;
                    pwdata_n    = cmd_write ? cmd_wdata : '0;
                    cmd_ready_n = 1'b0;
                    psel_n      = 1'b1;
                    state_n     = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                wait_cnt_n = '0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_n = pwrite ? '0 : prdata;
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_err_n   = 1'b0;
                end else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    // This wait cycle brings the count to TIMEOUT_CYCLES: abort.
                    rsp_rdata_n = '0;
                    rsp_err_n   = 1'b1;
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end else begin
                    wait_cnt_n = wait_cnt + 16'd1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            paddr     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cmd_ready <= cmd_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            paddr     <= paddr_n;
            psel      <= psel_n;
            penable   <= penable_n;
            pwrite    <= pwrite_n;
            pwdata    <= pwdata_n;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt  <= wait_cnt_n;
            rsp_err_q <= rsp_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: stimulus pushes expected APB and response entries,
// negedge monitors (which also model the APB slave and response consumer) pop and compare.
module tb_apb_master_bridge;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata;
    logic        psel, penable, pwrite;
    logic        pready = 1'b0;
    logic [31:0] prdata = 32'h0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] hold;
        logic [31:0] exp_cycle;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [15:0] n_access;
    } apb_t;

    rsp_t rsp_q[$];
    apb_t apb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int n_cmds   = 0;
    int setup_count = 0;
    int cur_waits = 0;
    logic [31:0] cur_prdata = 32'h0;

    apb_master_bridge #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk(pclk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .paddr(paddr),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .pwdata(pwdata),
        .pready(pready),
        .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Presents one command (called at a negedge) and queues its expected APB and response behaviour.
    task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic [31:0] slave_rdata, input int exp_access,
                                 input logic [31:0] exp_rdata, input logic exp_err, input int hold,
                                 input bit keep_valid);
        int k = 0;
        rsp_t r;
        apb_t a;
        cmd_valid = 1'b1;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        while (!cmd_ready && k < 100) begin
            @(negedge pclk);
            k++;
        end
        checkOutput("cmd_accept", {63'd0, cmd_ready}, 64'd1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        checkOutput("one_outstanding", 64'(rsp_q.size()), 64'd0);
        cur_waits  = waits;
        cur_prdata = slave_rdata;
        r.rdata     = exp_rdata;
        r.err       = exp_err;
        r.hold      = 16'(hold);
        r.exp_cycle = 32'(cycle + 2 + exp_access);
        rsp_q.push_back(r);
        a.addr     = addr;
        a.write    = write;
        a.wdata    = write ? wdata : 32'h0;
        a.n_access = 16'(exp_access);
        apb_q.push_back(a);
        n_cmds++;
        @(negedge pclk);
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int k = 0;
        while ((rsp_q.size() != 0 || apb_q.size() != 0 || !cmd_ready) && k < 200) begin
            @(negedge pclk);
            k++;
        end
        checkOutput("drain", {63'd0, k < 200}, 64'd1);
    endtask

    // APB protocol monitor plus slave model: wait states come from cur_waits.
    int  acc_cnt = 0;
    int  psel_cyc = 0;
    int  pen_cyc = 0;
    bit  prev_psel = 0;
    always @(negedge pclk) begin
        apb_t a;
        if (!rst_n) begin
            pready    = 1'b0;
            acc_cnt   = 0;
            psel_cyc  = 0;
            pen_cyc   = 0;
            prev_psel = 0;
        end else begin
            if (psel) begin
                if (!prev_psel) begin
                    checkOutput("apb_expected", 64'(apb_q.size() != 0), 64'd1);
                    checkOutput("setup_penable", {63'd0, penable}, 64'd0);
                end
                if (apb_q.size() != 0) begin
                    a = apb_q[0];
                    checkOutput("paddr", {32'd0, paddr}, {32'd0, a.addr});
                    checkOutput("pwrite", {63'd0, pwrite}, {63'd0, a.write});
                    checkOutput("pwdata", {32'd0, pwdata}, {32'd0, a.wdata});
                end
                if (!penable) setup_count++;
                psel_cyc++;
                if (penable) pen_cyc++;
            end else if (prev_psel) begin
                if (apb_q.size() != 0) begin
                    a = apb_q.pop_front();
                    checkOutput("psel_cycles", 64'(psel_cyc), 64'(a.n_access) + 64'd1);
                    checkOutput("penable_cycles", 64'(pen_cyc), 64'(a.n_access));
                end
                psel_cyc = 0;
                pen_cyc  = 0;
            end
            prev_psel = psel;
            if (psel && penable) begin
                pready = (acc_cnt >= cur_waits);
                acc_cnt++;
            end else begin
                pready  = 1'b0;
                acc_cnt = 0;
            end
            prdata = cur_prdata;
        end
    end

    // Response monitor and consumer: holds rsp_ready low for the queued number of cycles.
    int hold_cnt = 0;
    bit seen = 0;
    always @(negedge pclk) begin
        rsp_t e;
        if (!rst_n) begin
            rsp_ready = 1'b0;
            hold_cnt  = 0;
            seen      = 0;
        end else if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                checkOutput("rsp_unexpected", 64'd1, 64'd0);
                rsp_ready = 1'b1;
            end else begin
                e = rsp_q[0];
                if (!seen) begin
                    checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                    checkOutput("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                    checkOutput("rsp_latency", 64'(cycle), 64'(e.exp_cycle));
                    seen     = 1;
                    hold_cnt = 0;
                end else begin
                    checkOutput("hold_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                    checkOutput("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
                    checkOutput("hold_psel", {63'd0, psel}, 64'd0);
                end
                if (hold_cnt < int'(e.hold)) begin
                    rsp_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    rsp_ready = 1'b1;
                    void'(rsp_q.pop_front());
                    seen = 0;
                end
            end
        end else begin
            rsp_ready = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        repeat (2) @(negedge pclk);
        checkOutput("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        checkOutput("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        checkOutput("rst_paddr", {32'd0, paddr}, 64'd0);
        checkOutput("rst_psel", {63'd0, psel}, 64'd0);
        checkOutput("rst_penable", {63'd0, penable}, 64'd0);
        checkOutput("rst_pwrite", {63'd0, pwrite}, 64'd0);
        checkOutput("rst_pwdata", {32'd0, pwdata}, 64'd0);
        rst_n = 1'b1;
        @(negedge pclk);
        checkOutput("post_reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'hCAFE0000, 1, 32'h0, 1'b0, 0, 1'b0);
        waitIdle();
        applyStimulus(1'b0, 32'h20, 32'h0, 3, 32'h00000020, 4, 32'h00000020, 1'b0, 0, 1'b0);
        waitIdle();
        // Response held off for 5 cycles while the next command is already waiting.
        applyStimulus(1'b0, 32'h30, 32'hFFFFFFFF, 0, 32'hA5A50F0F, 1, 32'hA5A50F0F, 1'b0, 5, 1'b1);
        applyStimulus(1'b1, 32'h44, 32'h12345678, 1, 32'hFFFFFFFF, 2, 32'h0, 1'b0, 0, 1'b0);
        waitIdle();

        applyStimulus(1'b1, 32'h50, 32'h0BADF00D, 5, 32'h0, 6, 32'h0, 1'b0, 0, 1'b0);
        @(negedge pclk);
        checkOutput("pre_reset_penable", {63'd0, penable}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_psel", {63'd0, psel}, 64'd0);
        checkOutput("async_rst_penable", {63'd0, penable}, 64'd0);
        checkOutput("async_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        rsp_q.delete();
        apb_q.delete();
        @(negedge pclk);
        #1 rst_n = 1'b1;
        @(negedge pclk);
        checkOutput("rerst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        repeat (6) @(negedge pclk);

`ifdef APB_MASTER_TIMEOUT_EN
        applyStimulus(1'b0, 32'h40, 32'h0, 1000, 32'h77777777, 4, 32'h0, 1'b1, 0, 1'b0);
        waitIdle();
        applyStimulus(1'b0, 32'h05, 32'h0, 0, 32'h00000005, 1, 32'h00000005, 1'b0, 0, 1'b0);
        waitIdle();
`endif

        // Two commands back to back with cmd_valid never dropping in between.
        applyStimulus(1'b1, 32'h60, 32'h11112222, 0, 32'h0, 1, 32'h0, 1'b0, 0, 1'b1);
        applyStimulus(1'b0, 32'h64, 32'h0, 1, 32'h33334444, 2, 32'h33334444, 1'b0, 2, 1'b0);
        waitIdle();

        checkOutput("setup_count", 64'(setup_count), 64'(n_cmds));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB requester that drives the `dut_if` master-side signals (paddr, psel, penable, pwrite, pwdata).
- Turns a simple valid/ready command channel into compliant APB SETUP/ACCESS transfers.
- Returns read data and status on a valid/ready response channel.
- Sits between the test-sequence/CPU-side logic and the APB memory slave on the same pclk domain.

Parameters:
- ADDR_W, 32, width of cmd_addr and paddr.
- DATA_W, 32, width of write/read data.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit in cycles. Used only when APB_MASTER_TIMEOUT_EN is defined. Legal range 1..65535.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  transfer aborted by timeout.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_W  slave read data.

Behaviour:
- Reset:
  - Asynchronous on rst_n low.
  - All outputs 0: cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata.
  - FSM goes to IDLE.
  - Reset mid-transfer drops psel/penable immediately and discards any pending response.
  - First cycle after release is IDLE with cmd_ready=1.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid && cmd_ready: latch cmd_write/cmd_addr/cmd_wdata into paddr/pwrite/pwdata, set cmd_ready=0, go to SETUP.
  - For reads, pwdata is driven 0.
- SETUP (exactly 1 cycle): psel=1, penable=0. Then go to ACCESS.
- ACCESS:
  - psel=1, penable=1. pready is sampled every cycle.
  - pready=0: stay (wait state); paddr/pwrite/pwdata must not change.
  - pready=1: capture prdata into rsp_rdata for reads (0 for writes), rsp_err=0, psel=0, penable=0, rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_valid/rsp_rdata/rsp_err stable until rsp_ready=1.
  - On the handshake cycle: rsp_valid=0, cmd_ready=1, go to IDLE.
- pready is ignored in IDLE, SETUP and RESP.
- paddr/pwrite/pwdata keep their last value after a transfer. Checkers must only inspect them while psel=1.
- Latency, zero wait states:
  - Command accepted at edge N.
  - psel=1 in cycle N+1, penable=1 in cycle N+2, pready sampled at the end of N+2.
  - rsp_valid=1 in cycle N+3.
  - Minimum 4 cycles per transfer including the IDLE acceptance cycle.
- One transfer outstanding at a time. No back-to-back SETUP without returning through IDLE.
- cmd_valid while cmd_ready=0 is held off. The command is neither lost nor duplicated, provided the source holds it stable.

Optional Feature:
- APB_MASTER_TIMEOUT_EN defined:
  - A wait counter clears on SETUP→ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter equals TIMEOUT_CYCLES: psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, go to RESP.
  - pready=1 in the same cycle the limit is reached wins: normal completion, rsp_err=0.
- APB_MASTER_TIMEOUT_EN undefined:
  - No counter is built and rsp_err is tied 0.
  - ACCESS waits indefinitely for pready.

Test Plan:
- Write addr 0x10 data 0xDEADBEEF, pready=1 on first ACCESS cycle → psel high 2 cycles, penable high 1 cycle, pwrite=1, pwdata=0xDEADBEEF, rsp_valid at N+3 with rsp_err=0.
- Read addr 0x20, slave returns prdata=0x00000020 after 3 wait states → paddr stable through 4 ACCESS cycles, rsp_rdata=0x00000020.
- Read completes with rsp_ready held 0 for 5 cycles → rsp_valid/rsp_rdata stable, cmd_ready=0 throughout, psel=0; next command is accepted only after the handshake.
- rst_n pulsed low during ACCESS of a write → psel/penable/rsp_valid go 0 asynchronously; after release cmd_ready=1 and no response is emitted.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0 → abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0; a following read of 0x05 completes normally with rsp_err=0.
- Two commands presented back-to-back with cmd_valid held high → exactly two SETUP phases, separated by RESP and IDLE, and two responses in order.
